// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the write-back trace buffer.
package cv32e40x_pkg;

  // Width of the hart ID slice kept in each trace record.
  localparam int TRACE_HARTID_W = 4;

  // Saturation value of the dropped-event counter.
  localparam logic [15:0] TRACE_DROP_CNT_MAX = 16'hFFFF;

  // One captured write-back instruction (69 bits, pc in the MSBs).
  typedef struct packed {
    logic [31:0]               pc;
    logic [31:0]               instr;
    logic                      illegal;
    logic [TRACE_HARTID_W-1:0] hartid;
  } trace_rec_t;

  // Occupancy of the trace FIFO.
  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_e;

endpackage

// File: rtl/cv32e40x_trace_fifo_mem.sv
// Record storage and read/write pointers of the trace FIFO. The pointers wrap
// modulo DEPTH; push/pop are already qualified by the controller.
module cv32e40x_trace_fifo_mem
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  trace_rec_t wdata,
  output trace_rec_t rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  trace_rec_t    mem [DEPTH];

  // Pointer update: reset and clear return both pointers to slot 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Record write into the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; stale slots are never visible because level gates valid.
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cv32e40x_wb_trace_buffer.sv
// Captures write-back instructions (illegal only, or all) into a small FIFO
// for a trace reader, counting events dropped while the FIFO is full.
module cv32e40x_wb_trace_buffer
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter bit CAPTURE_ALL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid_i,
  input  logic                       wb_illegal_i,
  input  logic [31:0]                wb_pc_i,
  input  logic [31:0]                wb_instr_i,
  input  logic [31:0]                mhartid_i,
  input  logic                       clear_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output trace_rec_t                 trace_rec_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int              LW         = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]   LEVEL_FULL = LW'(DEPTH);

  occ_state_e    state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q;
  logic [15:0]   drop_cnt_q;
  logic          capture;
  logic          push;
  logic          pop;
  logic          drop;
  trace_rec_t    wr_rec;
  logic          unused_hartid;

  assign capture = wb_valid_i && (wb_illegal_i || CAPTURE_ALL);

  // Pop frees the head slot, so a capture into a full FIFO still lands when
  // the reader takes a record on the same edge. Clear and reset win over both.
  assign pop  = rst_n && !clear_i && trace_valid_o && trace_ready_i;
  assign push = rst_n && !clear_i && capture && ((state_q != OCC_FULL) || pop);
  assign drop = !clear_i && capture && (state_q == OCC_FULL) && !pop;

  assign wr_rec        = '{pc: wb_pc_i, instr: wb_instr_i, illegal: wb_illegal_i,
                           hartid: mhartid_i[TRACE_HARTID_W-1:0]};
  assign unused_hartid = ^mhartid_i[31:TRACE_HARTID_W];

  cv32e40x_trace_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_i),
    .push  (push),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (trace_rec_o)
  );

  // Next occupancy level and state from push/pop/clear.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    level_d = level_q;
    state_d = state_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (clear_i) level_d = '0;
    if (level_d == '0)             state_d = OCC_EMPTY;
    else if (level_d == LEVEL_FULL) state_d = OCC_FULL;
    else                            state_d = OCC_PARTIAL;
  end

  // Occupancy state and level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != TRACE_DROP_CNT_MAX) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign trace_valid_o = (level_q != '0);
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign level_o       = level_q;

endmodule

// File: tb/tb_cv32e40x_wb_trace_buffer.sv
// Self-checking bench: two instances (CAPTURE_ALL=0 and =1) share stimulus and
// are compared every cycle against a queue-based reference model, with
// directed sequences carrying literal expectations.
module tb_cv32e40x_wb_trace_buffer;
  import cv32e40x_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_illegal = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] hartid = '0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;

  logic          tv [2];
  trace_rec_t    tr [2];
  logic          ov [2];
  logic [15:0]   dc [2];
  logic [LW-1:0] lv [2];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model state per instance.
  trace_rec_t mq [2][$];
  bit         m_ovf [2];
  int         m_drop [2];

  cv32e40x_wb_trace_buffer #(.DEPTH(DEPTH), .CAPTURE_ALL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid), .wb_illegal_i(wb_illegal),
    .wb_pc_i(pc), .wb_instr_i(instr), .mhartid_i(hartid), .clear_i(clear),
    .trace_valid_o(tv[0]), .trace_ready_i(ready), .trace_rec_o(tr[0]),
    .overflow_o(ov[0]), .drop_cnt_o(dc[0]), .level_o(lv[0])
  );

  cv32e40x_wb_trace_buffer #(.DEPTH(DEPTH), .CAPTURE_ALL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid), .wb_illegal_i(wb_illegal),
    .wb_pc_i(pc), .wb_instr_i(instr), .mhartid_i(hartid), .clear_i(clear),
    .trace_valid_o(tv[1]), .trace_ready_i(ready), .trace_rec_o(tr[1]),
    .overflow_o(ov[1]), .drop_cnt_o(dc[1]), .level_o(lv[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records, a sticky flag and a saturating count.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit         cap;
      bit         do_pop;
      bit         full;
      trace_rec_t r;
      cap      = wb_valid && (wb_illegal || (i == 1));
      r.pc      = pc;
      r.instr   = instr;
      r.illegal = wb_illegal;
      r.hartid  = hartid[3:0];
      if (!rst_n || clear) begin
        mq[i].delete();
        m_ovf[i]  = 1'b0;
        m_drop[i] = 0;
      end else begin
        do_pop = (mq[i].size() != 0) && ready;
        full   = (mq[i].size() == DEPTH);
        if (do_pop) void'(mq[i].pop_front());
        if (cap) begin
          if (!full || do_pop) mq[i].push_back(r);
          else begin
            m_ovf[i] = 1'b1;
            if (m_drop[i] < 65535) m_drop[i]++;
          end
        end
      end
    end
  end

  // Compare both instances against the model shortly after every edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d level", i), 128'(lv[i]), 128'(mq[i].size()));
        check($sformatf("dut%0d valid", i), 128'(tv[i]), 128'(mq[i].size() != 0));
        check($sformatf("dut%0d overflow", i), 128'(ov[i]), 128'(m_ovf[i]));
        check($sformatf("dut%0d drop_cnt", i), 128'(dc[i]), 128'(m_drop[i]));
        if (mq[i].size() != 0)
          check($sformatf("dut%0d head_rec", i), 128'(tr[i]), 128'(mq[i][0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic ill, input logic [31:0] p);
    wb_valid   = v;
    wb_illegal = ill;
    pc         = p;
    instr      = p ^ 32'h0000_0013;
    hartid     = p >> 2;
  endtask

  initial begin
    logic [31:0] exp_pc [4];

    // Reset
    repeat (3) step();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset dut%0d level", i), 128'(lv[i]), 128'(0));
      check($sformatf("reset dut%0d valid", i), 128'(tv[i]), 128'(0));
      check($sformatf("reset dut%0d overflow", i), 128'(ov[i]), 128'(0));
      check($sformatf("reset dut%0d drop_cnt", i), 128'(dc[i]), 128'(0));
    end

    // Illegal then legal instruction, reader always ready
    ready = 1'b1;
    drive(1'b1, 1'b1, 32'h80);
    step();
    check("illegal capture valid", 128'(tv[0]), 128'(1));
    check("illegal capture pc", 128'(tr[0].pc), 128'(32'h80));
    check("illegal capture flag", 128'(tr[0].illegal), 128'(1));
    drive(1'b1, 1'b0, 32'h84);
    step();
    check("legal not captured", 128'(tv[0]), 128'(0));
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("single record drained", 128'(lv[0]), 128'(0));

    // Overflow by one with reader stalled, then in-order drain
    clear = 1'b1;
    step();
    clear = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(4 * k));
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
    check("overflow level", 128'(lv[0]), 128'(4));
    check("overflow flag", 128'(ov[0]), 128'(1));
    check("overflow drop_cnt", 128'(dc[0]), 128'(1));
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain order pc", 128'(tr[0].pc), 128'(32'h100 + 32'(4 * k)));
      step();
    end
    check("drained empty", 128'(tv[0]), 128'(0));

    // Push and pop together while full
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h200 + 32'(4 * k));
      step();
    end
    drive(1'b1, 1'b1, 32'h300);
    ready = 1'b1;
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("full push+pop level", 128'(lv[0]), 128'(4));
    check("full push+pop drop_cnt", 128'(dc[0]), 128'(1));
    exp_pc = '{32'h204, 32'h208, 32'h20C, 32'h300};
    for (int k = 0; k < 4; k++) begin
      check("full push+pop order", 128'(tr[0].pc), 128'(exp_pc[k]));
      step();
    end

    // Clear coinciding with a capture at level 3
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h700 + 32'(4 * k));
      step();
    end
    check("pre-clear level", 128'(lv[0]), 128'(3));
    drive(1'b1, 1'b1, 32'h70C);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    check("clear level", 128'(lv[0]), 128'(0));
    check("clear overflow", 128'(ov[0]), 128'(0));
    check("clear drop_cnt", 128'(dc[0]), 128'(0));
    check("clear valid", 128'(tv[0]), 128'(0));

    // CAPTURE_ALL: nine back-to-back legal instructions, reader ready
    ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b0, 32'h400 + 32'(4 * k));
      step();
      check("capture_all valid", 128'(tv[1]), 128'(1));
      check("capture_all pc", 128'(tr[1].pc), 128'(32'h400 + 32'(4 * k)));
    end
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("capture_all level", 128'(lv[1]), 128'(0));
    check("capture_all drop_cnt", 128'(dc[1]), 128'(0));
    check("capture_only_illegal level", 128'(lv[0]), 128'(0));

    // Reset mid-stream discards stored records
    ready = 1'b0;
    drive(1'b1, 1'b1, 32'h600);
    step();
    drive(1'b1, 1'b1, 32'h604);
    step();
    drive(1'b1, 1'b1, 32'h608);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'h500);
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("post-reset level", 128'(lv[0]), 128'(1));
    check("post-reset head pc", 128'(tr[0].pc), 128'(32'h500));
    ready = 1'b1;
    step();

    // Randomized traffic with varying reader throughput
    for (int blk = 0; blk < 8; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(90, 10);
      for (int c = 0; c < 250; c++) begin
        rst_n      = ($urandom_range(255) != 0);
        clear      = ($urandom_range(63) == 0);
        wb_valid   = ($urandom_range(3) != 0);
        wb_illegal = $urandom_range(1);
        pc         = $urandom;
        instr      = $urandom;
        hartid     = $urandom;
        ready      = ($urandom_range(99) < rdy_pct);
        step();
      end
    end
    rst_n = 1'b1;
    clear = 1'b0;

    // Drop counter saturation
    clear = 1'b1;
    step();
    clear = 1'b0;
    ready = 1'b0;
    drive(1'b1, 1'b1, 32'h900);
    repeat (DEPTH + 65535) step();
    check("saturate drop_cnt", 128'(dc[0]), 128'(16'hFFFF));
    step();
    check("saturate hold drop_cnt", 128'(dc[0]), 128'(16'hFFFF));
    check("saturate overflow", 128'(ov[0]), 128'(1));
    drive(1'b0, 1'b0, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40x_wb_trace_buffer.md
CV32E40X_WB_TRACE_BUFFER -- requirements
Module: cv32e40x_wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record slots (power of 2, 2..16).
REQ-002 SHALL have parameter CAPTURE_ALL, default 0; 0 = capture illegal instructions only, 1 = capture every valid WB instruction.
REQ-003 SHALL have port clk  input  1  core clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port wb_valid_i  input  1  WB-stage instruction valid (ex_wb_pipe instr_valid qualified by WB completion).
REQ-006 SHALL have port wb_illegal_i  input  1  WB-stage instruction is illegal.
REQ-007 SHALL have port wb_pc_i  input  32  WB-stage PC.
REQ-008 SHALL have port wb_instr_i  input  32  WB-stage instruction word.
REQ-009 SHALL have port mhartid_i  input  32  hart ID; bits [3:0] stored per record.
REQ-010 SHALL have port clear_i  input  1  flush all records and counters.
REQ-011 SHALL have port trace_valid_o  output  1  head record available.
REQ-012 SHALL have port trace_ready_i  input  1  reader accepts head record.
REQ-013 SHALL have port trace_rec_o  output  trace_rec_t (69 bits)  head record: pc[31:0], instr[31:0], illegal, hartid[3:0].
REQ-014 SHALL have port overflow_o  output  1  sticky: at least one event dropped since reset/clear.
REQ-015 SHALL have port drop_cnt_o  output  16  dropped-event count, saturating.
REQ-016 SHALL have port level_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Capture event SHALL be wb_valid_i && (wb_illegal_i || CAPTURE_ALL).
REQ-018 A capture event SHALL write one record into the tail slot on the same rising edge; trace_valid_o SHALL rise the following cycle (latency 1, no fall-through).
REQ-019 Pop SHALL occur on a rising edge with trace_valid_o && trace_ready_i; trace_rec_o SHALL present the next record, or trace_valid_o falls, in the following cycle.
REQ-020 trace_rec_o SHALL remain stable while trace_valid_o=1 and trace_ready_i=0.
REQ-021 trace_valid_o SHALL equal (level_o != 0); trace_rec_o SHALL be don't-care when trace_valid_o=0.
REQ-022 Push and pop in one cycle with level in 1..DEPTH SHALL both succeed; level unchanged.
REQ-023 Capture event when level=DEPTH without simultaneous pop SHALL be dropped: no write, overflow_o set, drop_cnt_o incremented.
REQ-024 drop_cnt_o SHALL saturate at 16'hFFFF; overflow_o stays 1.
REQ-025 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 clear_i=1 SHALL on that edge set level 0, both pointers 0, overflow_o 0, drop_cnt_o 0; it takes priority over a concurrent push or pop, and a concurrent capture event SHALL be discarded and not counted.
REQ-027 Occupancy state SHALL be EMPTY (level 0), PARTIAL (1..DEPTH-1), FULL (DEPTH); transitions only via push, pop, clear or reset per REQ-022..026.

Reset
REQ-028 On rst_n=0 at a rising edge: level_o=0, trace_valid_o=0, pointers=0, overflow_o=0, drop_cnt_o=0.
REQ-029 Reset SHALL override clear_i and any concurrent capture or pop; record storage SHALL NOT be reset.
REQ-030 Reset asserted mid-stream SHALL discard all stored records; the first post-reset capture SHALL appear as head.

Structure
REQ-031 trace_rec_t and TRACE_HARTID_W=4 SHALL be defined in cv32e40x_pkg.
REQ-032 Storage and pointers SHALL reside in one sub-module cv32e40x_trace_fifo_mem; counters and flags stay in the top.
REQ-033 Block SHALL be synthesizable, with no $display and no FORMAL guard.

Verification
REQ-034 DEPTH=4, CAPTURE_ALL=0: illegal at PC 0x80 then legal at 0x84, ready=1 -> exactly one record pc=0x80, illegal=1, valid one cycle after capture.
REQ-035 Five illegal events (PCs 0x100..0x110 step 4) with ready=0 -> level_o=4, overflow_o=1, drop_cnt_o=1; drain yields 0x100,0x104,0x108,0x10C in order.
REQ-036 Full FIFO with capture and pop in the same cycle -> level stays 4, drop_cnt_o unchanged, new record at tail.
REQ-037 Preset drop_cnt_o to 0xFFFF via 65535 drops, then one more drop -> drop_cnt_o stays 0xFFFF.
REQ-038 clear_i coinciding with a capture at level 3 -> level 0, overflow_o 0, drop_cnt_o 0, trace_valid_o 0 next cycle.
REQ-039 CAPTURE_ALL=1, 9 consecutive valid instructions with ready=1 -> all 9 records in order, pointer wrap exercised, no drops.
